// File: rtl/wb_pipe_buf.sv
// Writeback pipeline buffer: carries the register-file write triple through DEPTH stages.
// Optional forwarding lookup port is built only when the WB_FWD_EN macro is defined.
module wb_pipe_buf #(
  parameter int unsigned AW        = 5,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 1,
  parameter int unsigned X0_SQUASH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_en_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_data_o,
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic [15:0]   wb_cnt_o
);

  logic [DEPTH-1:0]         en_q,   en_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [15:0]              cnt_q,  cnt_d;
  logic                     squash;

  assign squash = (X0_SQUASH != 0) && (wb_addr == '0);

  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      en_d   = '0;
      addr_d = '0;
      data_d = '0;
    end else if (!stall_i) begin
      en_d[0]   = wb_en & ~squash;
      addr_d[0] = wb_addr;
      data_d[0] = wb_data;
      for (int k = 1; k < int'(DEPTH); k++) begin
        en_d[k]   = en_q[k-1];
        addr_d[k] = addr_q[k-1];
        data_d[k] = data_q[k-1];
      end
      // Entry leaving the last stage is retired; the count saturates rather than wrapping.
      if (en_q[DEPTH-1] && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wb_en_o   = en_q[DEPTH-1];
  assign wb_addr_o = addr_q[DEPTH-1];
  assign wb_data_o = data_q[DEPTH-1];
  assign wb_cnt_o  = cnt_q;

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the lowest-index match is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (en_q[k] && (addr_q[k] == fwd_addr) && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[k];
      end
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

// File: doc/wb_pipe_buf.md
# wb_pipe_buf

Parametrised writeback pipeline buffer, the successor to the single-stage MEM/WB register. It carries the register-file write triple (enable, address, data) through a configurable number of stages toward the register file. It adds stall, flush and x0 squashing, and a saturating retire counter. An optional forwarding lookup port serves the ID-stage hazard logic with the youngest in-flight value for a register address.

## Interface
- AW, 5, register address width
- DW, 32, write data width
- DEPTH, 1, number of buffer stages (legal 1..4)
- X0_SQUASH, 1, when 1 writes to address 0 are stored with enable cleared
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- stall_i  input  1  hold all stages this cycle
- flush_i  input  1  invalidate all stages this cycle
- wb_en  input  1  incoming write enable
- wb_addr  input  AW  incoming write address
- wb_data  input  DW  incoming write data
- wb_en_o  output  1  write enable to register file (last stage)
- wb_addr_o  output  AW  write address (last stage)
- wb_data_o  output  DW  write data (last stage)
- fwd_addr  input  AW  forwarding lookup address
- fwd_hit  output  1  lookup matched a valid in-flight write
- fwd_data  output  DW  data of the youngest matching entry
- wb_cnt_o  output  16  count of retired writes, saturating

## Operation
- Stage chain s[0]..s[DEPTH-1]. Each stage holds {en, addr, data}. s[0] captures the inputs and s[DEPTH-1] drives the wb_*_o outputs directly from registers.
- Normal edge (stall_i=0, flush_i=0): s[0] takes the inputs and s[k] takes s[k-1]. The entry leaving s[DEPTH-1] is retired.
- x0 squash: with X0_SQUASH=1 and wb_addr==0, s[0].en is written 0. Addr and data are still captured.
- Stall (stall_i=1, flush_i=0): every stage holds. The inputs are ignored, and upstream must hold them.
- Flush (flush_i=1): every stage en is cleared to 0, and addr/data are cleared to 0. Flush has priority over stall. The inputs presented in the flush cycle are discarded.
- Retire counter: increments by 1 on each edge where stall_i=0, flush_i=0 and s[DEPTH-1].en=1. It saturates at 16'hFFFF and never wraps.
- Forwarding (combinational): compare fwd_addr against every stage with en=1. The lowest-index (youngest) match drives fwd_data and sets fwd_hit=1. fwd_addr==0 never hits. With no match, fwd_hit=0 and fwd_data=0. Lookup ignores the current inputs and does not depend on stall_i/flush_i.

## Timing
- Reset (rst=0, asynchronous): all stage fields, wb_en_o, wb_addr_o, wb_data_o and wb_cnt_o go to 0 immediately, independent of clk. Deasserting mid-stream restarts from an empty pipe.
- Latency: an input accepted at edge N appears on the outputs after edge N+DEPTH-1 (DEPTH=1 gives one-cycle register behaviour), plus one edge per stalled cycle.
- Stall cycles add no bubbles and drop no entries. Retire happens only on non-stalled edges.
- stall_i and flush_i are sampled at the rising edge.
- fwd_hit/fwd_data follow fwd_addr and the stage state in the same cycle with no register.
- Simultaneous stall_i=1 and flush_i=1: flush is applied and no retire is counted.

## Configuration
- WB_FWD_EN defined: the comparator/priority mux is built and fwd_hit/fwd_data behave as above.
- WB_FWD_EN undefined: no comparators are built, fwd_hit is tied 0, fwd_data is tied 0, and fwd_addr is unused. All other behaviour is identical.

## Test plan
- Reset: drive inputs nonzero and pulse rst low between edges. All outputs read 0 at once, and wb_cnt_o=0 after release.
- Latency, DEPTH=3: present {1,5'd7,32'hDEADBEEF} at edge 0, then zeros. The outputs show {1,7,DEADBEEF} after edge 2 only, and wb_cnt_o=1 after edge 3.
- Stall: with the entry in s[1] of DEPTH=3, hold stall_i=1 for 4 cycles. The outputs and wb_cnt_o are frozen, and the entry exits 4 cycles late, unchanged.
- Flush vs stall: load 3 valid entries, then assert stall_i=1 and flush_i=1 together. The next cycle shows wb_en_o=0, all stages invalid, and no counter increment.
- x0 and forwarding (WB_FWD_EN): write addr 0 data 32'h1, then addr 9 data 32'hA, then addr 9 data 32'hB.
  - wb_en_o is never 1 for addr 0.
  - fwd_addr=9 returns hit=1, data=32'hB; fwd_addr=0 returns hit=0.
- Saturation: preload the count, or run 65537 valid retires. wb_cnt_o holds at 16'hFFFF.
